game_flow_ctrl: RTL
===================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level round sequencer for the rhythm-game display path. Walks the game through
//  idle, song select, countdown, play, pause and result phases, paced by VGA frame ticks.
//  Drives music_id, the active-low rst_track and track_run into the track/VGA datapath,
//  and latches the final score at song end.
// PARAMETERS
//  NUM_SONGS     4       number of selectable songs; music_id range 0..NUM_SONGS-1 (<=16)
//  COUNT_FRAMES  60      frame ticks per countdown step
//  SONG_FRAMES   3600    frame ticks of play per round (<=65535)
//  KEY_START     8'h20   start / pause / resume / acknowledge key code
//  KEY_NEXT      8'h44   next song key code
//  KEY_PREV      8'h41   previous song key code
//  KEY_ESC       8'h1B   abort-to-select key code
// PORTS
//  clk          in   1   system clock, same clock as the VGA timing counters
//  rst          in   1   synchronous, active-low reset
//  vs           in   1   VGA vertical sync, synchronous to clk
//  keys         in   8   current key code
//  key_state    in   1   1 = key held
//  score        in   32  running score from the track controller
//  state        out  3   0 IDLE, 1 SELECT, 2 COUNT, 3 PLAY, 4 PAUSE, 5 RESULT
//  music_id     out  4   selected song
//  rst_track    out  1   active-low reset to the track controller
//  track_run    out  1   1 = track controller advances notes
//  countdown    out  2   countdown digit 3..1 in COUNT, else 0
//  play_frames  out  16  frame ticks elapsed in the current round
//  final_score  out  32  score latched on PLAY->RESULT
//  round_done   out  1   one-cycle pulse on PLAY->RESULT
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state=IDLE, music_id=0, rst_track=0, track_run=0,
//   countdown=0, play_frames=0, final_score=0, round_done=0, edge registers cleared.
//   A mid-round reset aborts immediately and leaves no residue.
//  frame_tick = vs & ~vs_q (one register). key_ev = key_state & ~key_state_q; the code is
//   keys sampled in the same cycle. Held keys never repeat.
//  All outputs are registered and change on the same edge as state.
//  IDLE:   any key_ev -> SELECT.
//  SELECT: KEY_NEXT: music_id+1, wraps NUM_SONGS-1 -> 0. KEY_PREV: music_id-1, wraps
//          0 -> NUM_SONGS-1. KEY_START -> COUNT, countdown=3, frame cnt=0, play_frames=0.
//  COUNT:  each frame_tick increments an internal counter. When the counter reaches
//          COUNT_FRAMES-1, it clears and countdown decrements. A decrement from 1 goes
//          to PLAY with countdown=0. KEY_ESC -> SELECT.
//  PLAY:   each frame_tick increments play_frames. A tick with play_frames==SONG_FRAMES-1
//          -> RESULT, play_frames=SONG_FRAMES, final_score<=score, round_done=1 for one
//          cycle. KEY_START -> PAUSE. KEY_ESC -> SELECT.
//          Priority in one cycle: KEY_ESC > song end > KEY_START. A tick with a pause key
//          is still counted.
//  PAUSE:  play_frames frozen, ticks ignored. KEY_START -> PLAY. KEY_ESC -> SELECT.
//  RESULT: holds play_frames and final_score. KEY_START -> SELECT; music_id kept.
//  Other keys in any state: no effect. Undefined state codes (6,7) -> IDLE next cycle.
//  rst_track=1 only in PLAY, PAUSE and RESULT (so score stays visible in RESULT).
//   Entering SELECT drives it 0 on that edge, clearing the track controller.
//  track_run=1 only in PLAY.
// TESTING
//  (params COUNT_FRAMES=2, SONG_FRAMES=5, NUM_SONGS=4; vs pulse every 20 clks)
//  1 Reset, press any key, then KEY_PREV x1 and KEY_NEXT x2 -> state 0->1, music_id 0->3->0->1.
//  2 KEY_START in SELECT -> countdown 3,2,1 every 2 ticks; PLAY after the 6th tick;
//    rst_track=1 and track_run=1 on the same edge.
//  3 Play 5 ticks with score=32'd1234 -> RESULT, final_score=1234, round_done high
//    exactly 1 clk, play_frames=5, rst_track stays 1.
//  4 KEY_START after 2 play ticks, 3 ticks in PAUSE, KEY_START again -> play_frames
//    holds at 2, track_run=0 in PAUSE, resumes counting to 5.
//  5 KEY_ESC coinciding with the final tick -> SELECT, rst_track=0, round_done stays 0.
//  6 rst=0 mid-PLAY for 1 clk -> all outputs at reset values next edge. Holding KEY_NEXT
//    for 50 clks in SELECT -> music_id advances once.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - round sequencer for the rhythm-game display path
// Walks idle/select/countdown/play/pause/result, paced by VGA frame ticks.
module game_flow_ctrl #(
   parameter int          NUM_SONGS    = 4,
   parameter int          COUNT_FRAMES = 60,
   parameter int          SONG_FRAMES  = 3600,
   parameter logic [7:0]  KEY_START    = 8'h20,
   parameter logic [7:0]  KEY_NEXT     = 8'h44,
   parameter logic [7:0]  KEY_PREV     = 8'h41,
   parameter logic [7:0]  KEY_ESC      = 8'h1B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vs,
   input  logic [7:0]  keys,
   input  logic        key_state,
   input  logic [31:0] score,
   output logic [2:0]  state,
   output logic [3:0]  music_id,
   output logic        rst_track,
   output logic        track_run,
   output logic [1:0]  countdown,
   output logic [15:0] play_frames,
   output logic [31:0] final_score,
   output logic        round_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_COUNT  = 3'd2,
      S_PLAY   = 3'd3,
      S_PAUSE  = 3'd4,
      S_RESULT = 3'd5
   } state_t;

   state_t      st;
   logic        vs_q;
   logic        key_state_q;
   logic [15:0] frame_cnt;
   logic        frame_tick;
   logic        key_ev;
   logic        key_start;
   logic        key_next;
   logic        key_prev;
   logic        key_esc;

   assign frame_tick = vs & ~vs_q;
   assign key_ev     = key_state & ~key_state_q;
   assign key_start  = key_ev && (keys == KEY_START);
   assign key_next   = key_ev && (keys == KEY_NEXT);
   assign key_prev   = key_ev && (keys == KEY_PREV);
   assign key_esc    = key_ev && (keys == KEY_ESC);
   assign state      = st;

   always_ff @(posedge clk) begin
      if (!rst) begin
         st          <= S_IDLE;
         vs_q        <= 1'b0;
         key_state_q <= 1'b0;
         frame_cnt   <= 16'd0;
         music_id    <= 4'd0;
         rst_track   <= 1'b0;
         track_run   <= 1'b0;
         countdown   <= 2'd0;
         play_frames <= 16'd0;
         final_score <= 32'd0;
         round_done  <= 1'b0;
      end else begin
         vs_q        <= vs;
         key_state_q <= key_state;
         round_done  <= 1'b0;
         case (st)
            S_IDLE: begin
               if (key_ev) st <= S_SELECT;
            end
            S_SELECT: begin
               if (key_next) begin
                  music_id <= (music_id == 4'(NUM_SONGS - 1)) ? 4'd0 : music_id + 4'd1;
               end else if (key_prev) begin
                  music_id <= (music_id == 4'd0) ? 4'(NUM_SONGS - 1) : music_id - 4'd1;
               end else if (key_start) begin
                  st          <= S_COUNT;
                  countdown   <= 2'd3;
                  frame_cnt   <= 16'd0;
                  play_frames <= 16'd0;
               end
            end
            S_COUNT: begin
               if (key_esc) begin
                  st        <= S_SELECT;
                  countdown <= 2'd0;
               end else if (frame_tick) begin
                  if (frame_cnt == 16'(COUNT_FRAMES - 1)) begin
                     frame_cnt <= 16'd0;
                     countdown <= countdown - 2'd1;
                     // The last digit hands straight over to play on the same edge.
                     if (countdown == 2'd1) begin
                        st        <= S_PLAY;
                        rst_track <= 1'b1;
                        track_run <= 1'b1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 16'd1;
                  end
               end
            end
            S_PLAY: begin
               if (key_esc) begin
                  st        <= S_SELECT;
                  rst_track <= 1'b0;
                  track_run <= 1'b0;
               end else if (frame_tick && play_frames == 16'(SONG_FRAMES - 1)) begin
                  st          <= S_RESULT;
                  play_frames <= 16'(SONG_FRAMES);
                  final_score <= score;
                  round_done  <= 1'b1;
                  track_run   <= 1'b0;
               end else begin
                  // A tick arriving with the pause key is still counted.
                  if (frame_tick) play_frames <= play_frames + 16'd1;
                  if (key_start) begin
                     st        <= S_PAUSE;
                     track_run <= 1'b0;
                  end
               end
            end
            S_PAUSE: begin
               if (key_start) begin
                  st        <= S_PLAY;
                  track_run <= 1'b1;
               end else if (key_esc) begin
                  st        <= S_SELECT;
                  rst_track <= 1'b0;
               end
            end
            S_RESULT: begin
               // rst_track stays high here so the score remains on screen.
               if (key_start) begin
                  st        <= S_SELECT;
                  rst_track <= 1'b0;
               end
            end
            default: begin
               st        <= S_IDLE;
               rst_track <= 1'b0;
               track_run <= 1'b0;
               countdown <= 2'd0;
            end
         endcase
      end
   end

endmodule
